// File: rtl/rs_alu_pkg.sv
// Shared widths, opcodes and the reservation-station entry layout for the integer ALU RS.
package rs_alu_pkg;

    localparam int RS_SIZE_DEF  = 8;
    localparam int ROB_ID_WIDTH = 5;
    localparam int REG_W        = 32;
    localparam int INST_ADDR_W  = 32;
    localparam int ALU_OP_W     = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_NOP  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_SLT  = 5'd9,
        ALU_SLTU = 5'd10,
        ALU_BEQ  = 5'd11,
        ALU_BNE  = 5'd12,
        ALU_JAL  = 5'd13,
        ALU_JALR = 5'd14
    } alu_op_e;

    typedef struct packed {
        logic                    valid;
        logic [ALU_OP_W-1:0]     op;
        logic [REG_W-1:0]        vj;
        logic [REG_W-1:0]        vk;
        logic [ROB_ID_WIDTH-1:0] qj;
        logic [ROB_ID_WIDTH-1:0] qk;
        logic                    qj_pend;
        logic                    qk_pend;
        logic [REG_W-1:0]        imm;
        logic [INST_ADDR_W-1:0]  pc;
        logic [ROB_ID_WIDTH-1:0] dest;
        logic [INST_ADDR_W-1:0]  pred_target;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Age matrix for the RS: age[i][j]=1 means entry i is older than entry j.
// Picks the single ready entry that no other ready entry is older than.
module rs_age_select #(
    parameter int RS_SIZE  = 8,
    parameter int RS_IDX_W = $clog2(RS_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                alloc_en,
    input  logic [RS_IDX_W-1:0] alloc_idx,
    input  logic [RS_SIZE-1:0]  valid,
    input  logic [RS_SIZE-1:0]  ready,
    output logic                sel_valid,
    output logic [RS_SIZE-1:0]  sel_onehot,
    output logic [RS_IDX_W-1:0] sel_idx
);

    logic [RS_SIZE-1:0] age [RS_SIZE];
    logic [RS_SIZE-1:0] blocked;

    // A new entry is younger than every live entry; clearing its row drops stale history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
        end else if (alloc_en) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (RS_IDX_W'(i) == alloc_idx) age[i] <= '0;
                else age[i][alloc_idx] <= valid[i];
            end
        end
    end

    always_comb begin
        blocked    = '0;
        sel_onehot = '0;
        sel_idx    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (j != i && ready[j] && age[j][i]) blocked[i] = 1'b1;
            end
            if (ready[i] && !blocked[i]) begin
                sel_onehot[i] = 1'b1;
                sel_idx       = RS_IDX_W'(i);
            end
        end
        sel_valid = |ready;
    end

endmodule

// File: rtl/rs_alu.sv
// Reservation station for the integer ALU: buffers dispatched uops, snoops the CDB
// for operands and issues the oldest ready entry into alu_common.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int RS_IDX_W = $clog2(RS_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    disp_valid_i,
    output logic                    disp_ready_o,
    input  logic [ALU_OP_W-1:0]     disp_op_i,
    input  logic [REG_W-1:0]        disp_vj_i,
    input  logic [REG_W-1:0]        disp_vk_i,
    input  logic [ROB_ID_WIDTH-1:0] disp_qj_i,
    input  logic [ROB_ID_WIDTH-1:0] disp_qk_i,
    input  logic                    disp_qj_valid_i,
    input  logic                    disp_qk_valid_i,
    input  logic [REG_W-1:0]        disp_imm_i,
    input  logic [INST_ADDR_W-1:0]  disp_pc_i,
    input  logic [ROB_ID_WIDTH-1:0] disp_dest_i,
    input  logic [INST_ADDR_W-1:0]  disp_pred_target_i,
    input  logic                    cdb_valid_i,
    input  logic [ROB_ID_WIDTH-1:0] cdb_rob_id_i,
    input  logic [REG_W-1:0]        cdb_value_i,
    input  logic                    alu_ready_i,
    output logic                    iss_valid_o,
    output logic [ALU_OP_W-1:0]     iss_op_o,
    output logic [REG_W-1:0]        iss_vj_o,
    output logic [REG_W-1:0]        iss_vk_o,
    output logic [REG_W-1:0]        iss_imm_o,
    output logic [INST_ADDR_W-1:0]  iss_pc_o,
    output logic [ROB_ID_WIDTH-1:0] iss_dest_o,
    output logic [INST_ADDR_W-1:0]  iss_pred_target_o
);

    rs_entry_t             rs_q [RS_SIZE];
    rs_entry_t             new_entry;
    rs_entry_t             sel_entry;
    logic [RS_SIZE-1:0]    valid_vec;
    logic [RS_SIZE-1:0]    ready_vec;
    logic [RS_SIZE-1:0]    sel_onehot;
    logic [RS_IDX_W-1:0]   sel_idx;
    logic [RS_IDX_W-1:0]   free_idx;
    logic                  sel_valid;
    logic                  disp_fire;
    logic                  issue_fire;
    logic                  cap_j;
    logic                  cap_k;

    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            valid_vec[i] = rs_q[i].valid;
            ready_vec[i] = rs_q[i].valid && !rs_q[i].qj_pend && !rs_q[i].qk_pend;
            if (!rs_q[i].valid) free_idx = RS_IDX_W'(i);
        end
    end

    assign disp_ready_o = ~&valid_vec;
    assign disp_fire    = disp_valid_i && disp_ready_o && !flush_i;
    assign iss_valid_o  = sel_valid && !flush_i;
    assign issue_fire   = iss_valid_o && alu_ready_i;

    // An operand broadcast in the dispatch cycle would otherwise be missed by the new entry.
    always_comb begin
        cap_j = cdb_valid_i && disp_qj_valid_i && (cdb_rob_id_i == disp_qj_i);
        cap_k = cdb_valid_i && disp_qk_valid_i && (cdb_rob_id_i == disp_qk_i);
        new_entry             = '0;
        new_entry.valid       = 1'b1;
        new_entry.op          = disp_op_i;
        new_entry.vj          = cap_j ? cdb_value_i : disp_vj_i;
        new_entry.vk          = cap_k ? cdb_value_i : disp_vk_i;
        new_entry.qj          = disp_qj_i;
        new_entry.qk          = disp_qk_i;
        new_entry.qj_pend     = disp_qj_valid_i && !cap_j;
        new_entry.qk_pend     = disp_qk_valid_i && !cap_k;
        new_entry.imm         = disp_imm_i;
        new_entry.pc          = disp_pc_i;
        new_entry.dest        = disp_dest_i;
        new_entry.pred_target = disp_pred_target_i;
    end

    // Wakeup lands in the entry only, so issue follows one cycle after the last operand.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) rs_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < RS_SIZE; i++) rs_q[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (disp_fire && free_idx == RS_IDX_W'(i)) begin
                    rs_q[i] <= new_entry;
                end else begin
                    if (issue_fire && sel_onehot[i]) rs_q[i].valid <= 1'b0;
                    if (rs_q[i].valid && rs_q[i].qj_pend && cdb_valid_i && rs_q[i].qj == cdb_rob_id_i) begin
                        rs_q[i].vj      <= cdb_value_i;
                        rs_q[i].qj_pend <= 1'b0;
                    end
                    if (rs_q[i].valid && rs_q[i].qk_pend && cdb_valid_i && rs_q[i].qk == cdb_rob_id_i) begin
                        rs_q[i].vk      <= cdb_value_i;
                        rs_q[i].qk_pend <= 1'b0;
                    end
                end
            end
        end
    end

    rs_age_select #(
        .RS_SIZE (RS_SIZE),
        .RS_IDX_W(RS_IDX_W)
    ) u_age_select (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .alloc_en  (disp_fire),
        .alloc_idx (free_idx),
        .valid     (valid_vec),
        .ready     (ready_vec),
        .sel_valid (sel_valid),
        .sel_onehot(sel_onehot),
        .sel_idx   (sel_idx)
    );

    always_comb begin
        sel_entry         = rs_q[sel_idx];
        iss_op_o          = iss_valid_o ? sel_entry.op          : '0;
        iss_vj_o          = iss_valid_o ? sel_entry.vj          : '0;
        iss_vk_o          = iss_valid_o ? sel_entry.vk          : '0;
        iss_imm_o         = iss_valid_o ? sel_entry.imm         : '0;
        iss_pc_o          = iss_valid_o ? sel_entry.pc          : '0;
        iss_dest_o        = iss_valid_o ? sel_entry.dest        : '0;
        iss_pred_target_o = iss_valid_o ? sel_entry.pred_target : '0;
    end

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: a vector table for single-entry behaviour plus
// hand-written fill, flush and asynchronous-reset sequences.
module tb_rs_alu;
    import rs_alu_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush_i;
    logic                    disp_valid_i;
    logic                    disp_ready_o;
    logic [ALU_OP_W-1:0]     disp_op_i;
    logic [REG_W-1:0]        disp_vj_i, disp_vk_i, disp_imm_i;
    logic [ROB_ID_WIDTH-1:0] disp_qj_i, disp_qk_i, disp_dest_i;
    logic                    disp_qj_valid_i, disp_qk_valid_i;
    logic [INST_ADDR_W-1:0]  disp_pc_i, disp_pred_target_i;
    logic                    cdb_valid_i;
    logic [ROB_ID_WIDTH-1:0] cdb_rob_id_i;
    logic [REG_W-1:0]        cdb_value_i;
    logic                    alu_ready_i;
    logic                    iss_valid_o;
    logic [ALU_OP_W-1:0]     iss_op_o;
    logic [REG_W-1:0]        iss_vj_o, iss_vk_o, iss_imm_o;
    logic [INST_ADDR_W-1:0]  iss_pc_o, iss_pred_target_o;
    logic [ROB_ID_WIDTH-1:0] iss_dest_o;

    int vectors = 0;
    int miscompares = 0;

    rs_alu dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_op_i(disp_op_i),
        .disp_vj_i(disp_vj_i), .disp_vk_i(disp_vk_i), .disp_qj_i(disp_qj_i), .disp_qk_i(disp_qk_i),
        .disp_qj_valid_i(disp_qj_valid_i), .disp_qk_valid_i(disp_qk_valid_i), .disp_imm_i(disp_imm_i),
        .disp_pc_i(disp_pc_i), .disp_dest_i(disp_dest_i), .disp_pred_target_i(disp_pred_target_i),
        .cdb_valid_i(cdb_valid_i), .cdb_rob_id_i(cdb_rob_id_i), .cdb_value_i(cdb_value_i),
        .alu_ready_i(alu_ready_i), .iss_valid_o(iss_valid_o), .iss_op_o(iss_op_o),
        .iss_vj_o(iss_vj_o), .iss_vk_o(iss_vk_o), .iss_imm_o(iss_imm_o), .iss_pc_o(iss_pc_o),
        .iss_dest_o(iss_dest_o), .iss_pred_target_o(iss_pred_target_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [4:0]  op;
        logic [31:0] vj, vk;
        logic [4:0]  qj;
        logic        qjv;
        logic [4:0]  qk;
        logic        qkv;
        logic [4:0]  dest;
        logic        cv;
        logic [4:0]  cid;
        logic [31:0] cval;
        logic        ar;
        logic        e_iv;
        logic [4:0]  e_op;
        logic [31:0] e_vj, e_vk;
        logic [4:0]  e_dest;
    } vec_t;

    vec_t vecs[$];

    // Side fields are derived from dest so a swapped or dropped field shows up.
    function automatic logic [31:0] imm_of(input logic [4:0] d);
        return 32'h0000_1100 | {27'd0, d};
    endfunction
    function automatic logic [31:0] pc_of(input logic [4:0] d);
        return 32'h8000_0000 + {25'd0, d, 2'b00};
    endfunction
    function automatic logic [31:0] pred_of(input logic [4:0] d);
        return pc_of(d) + 32'h40;
    endfunction

    function automatic vec_t mk(input logic dv, input alu_op_e op, input logic [31:0] vj, vk,
                                input logic [4:0] qj, input logic qjv, input logic [4:0] qk, input logic qkv,
                                input logic [4:0] dest, input logic cv, input logic [4:0] cid,
                                input logic [31:0] cval, input logic ar, input logic e_iv,
                                input alu_op_e e_op, input logic [31:0] e_vj, e_vk, input logic [4:0] e_dest);
        vec_t v;
        v.dv = dv; v.op = op; v.vj = vj; v.vk = vk; v.qj = qj; v.qjv = qjv; v.qk = qk; v.qkv = qkv;
        v.dest = dest; v.cv = cv; v.cid = cid; v.cval = cval; v.ar = ar;
        v.e_iv = e_iv; v.e_op = e_op; v.e_vj = e_vj; v.e_vk = e_vk; v.e_dest = e_dest;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [4:0] op, input logic [31:0] vj, vk,
                                 input logic [4:0] qj, input logic qjv, input logic [4:0] qk, input logic qkv,
                                 input logic [4:0] dest, input logic cv, input logic [4:0] cid,
                                 input logic [31:0] cval, input logic ar, input logic fl);
        disp_valid_i = dv; disp_op_i = op; disp_vj_i = vj; disp_vk_i = vk;
        disp_qj_i = qj; disp_qj_valid_i = qjv; disp_qk_i = qk; disp_qk_valid_i = qkv;
        disp_dest_i = dest; disp_imm_i = imm_of(dest); disp_pc_i = pc_of(dest); disp_pred_target_i = pred_of(dest);
        cdb_valid_i = cv; cdb_rob_id_i = cid; cdb_value_i = cval; alu_ready_i = ar; flush_i = fl;
    endtask

    task automatic idle(input logic ar);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, ar, 1'b0);
    endtask

    task automatic dispReady(input logic [4:0] dest, input logic [31:0] vj, input logic ar);
        applyStimulus(1'b1, ALU_ADD, vj, 32'd1, 5'd0, 1'b0, 5'd0, 1'b0, dest, 1'b0, 5'd0, 32'd0, ar, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle(1'b1);
        @(negedge clk);
        checkOutput("reset_iss_valid", {31'd0, iss_valid_o}, 32'd0);
        checkOutput("reset_disp_ready", {31'd0, disp_ready_o}, 32'd1);
        nextCycle();
        rst = 1'b1;

        vecs.push_back(mk(1, ALU_ADD, 5, 7, 0, 0, 0, 0, 3, 0, 0, 0, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, ALU_ADD, 5, 7, 3));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(1, ALU_SUB, 32'hDEAD, 2, 4, 1, 0, 0, 1, 0, 0, 0, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h10, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, ALU_SUB, 32'h10, 2, 1));
        vecs.push_back(mk(1, ALU_AND, 3, 32'hBAD, 0, 0, 6, 1, 2, 1, 6, 32'h99, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, ALU_AND, 3, 32'h99, 2));
        vecs.push_back(mk(1, ALU_OR, 0, 1, 9, 1, 0, 0, 5, 1, 8, 32'h55, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h77, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h42, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, ALU_OR, 32'h42, 1, 5));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, ALU_OR, 32'h42, 1, 5));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(1, ALU_XOR, 32'hA, 32'hB, 3, 0, 3, 0, 6, 1, 3, 32'hEE, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, ALU_XOR, 32'hA, 32'hB, 6));
        vecs.push_back(mk(1, ALU_SLL, 0, 1, 7, 1, 0, 0, 10, 0, 0, 0, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(1, ALU_SRL, 20, 2, 0, 0, 0, 0, 11, 0, 0, 0, 1,  0, ALU_NOP, 0, 0, 0));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h33, 1,  1, ALU_SRL, 20, 2, 11));
        vecs.push_back(mk(1, ALU_SRA, 40, 3, 0, 0, 0, 0, 12, 0, 0, 0, 0,  1, ALU_SLL, 32'h33, 1, 10));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, ALU_SLL, 32'h33, 1, 10));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, ALU_SRA, 40, 3, 12));
        vecs.push_back(mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, ALU_NOP, 0, 0, 0));

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].dv, vecs[n].op, vecs[n].vj, vecs[n].vk, vecs[n].qj, vecs[n].qjv,
                          vecs[n].qk, vecs[n].qkv, vecs[n].dest, vecs[n].cv, vecs[n].cid,
                          vecs[n].cval, vecs[n].ar, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("v%0d_disp_ready", n), {31'd0, disp_ready_o}, 32'd1);
            checkOutput($sformatf("v%0d_iss_valid", n), {31'd0, iss_valid_o}, {31'd0, vecs[n].e_iv});
            checkOutput($sformatf("v%0d_iss_op", n), {27'd0, iss_op_o}, {27'd0, vecs[n].e_op});
            checkOutput($sformatf("v%0d_iss_vj", n), iss_vj_o, vecs[n].e_vj);
            checkOutput($sformatf("v%0d_iss_vk", n), iss_vk_o, vecs[n].e_vk);
            checkOutput($sformatf("v%0d_iss_dest", n), {27'd0, iss_dest_o}, {27'd0, vecs[n].e_dest});
            checkOutput($sformatf("v%0d_iss_imm", n), iss_imm_o, vecs[n].e_iv ? imm_of(vecs[n].e_dest) : 32'd0);
            checkOutput($sformatf("v%0d_iss_pc", n), iss_pc_o, vecs[n].e_iv ? pc_of(vecs[n].e_dest) : 32'd0);
            checkOutput($sformatf("v%0d_iss_pred", n), iss_pred_target_o, vecs[n].e_iv ? pred_of(vecs[n].e_dest) : 32'd0);
            nextCycle();
        end

        // Fill all eight entries while the ALU stalls, then drain in dispatch order.
        for (int k = 0; k < 8; k++) begin
            dispReady(5'(k), 32'(100 + k), 1'b0);
            @(negedge clk);
            checkOutput($sformatf("fill%0d_disp_ready", k), {31'd0, disp_ready_o}, 32'd1);
            checkOutput($sformatf("fill%0d_iss_valid", k), {31'd0, iss_valid_o}, (k > 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fill%0d_iss_dest", k), {27'd0, iss_dest_o}, 32'd0);
            nextCycle();
        end
        dispReady(5'd20, 32'd999, 1'b0);
        @(negedge clk);
        checkOutput("full_disp_ready", {31'd0, disp_ready_o}, 32'd0);
        nextCycle();
        for (int k = 0; k < 8; k++) begin
            idle(1'b1);
            @(negedge clk);
            checkOutput($sformatf("drain%0d_disp_ready", k), {31'd0, disp_ready_o}, (k == 0) ? 32'd0 : 32'd1);
            checkOutput($sformatf("drain%0d_iss_valid", k), {31'd0, iss_valid_o}, 32'd1);
            checkOutput($sformatf("drain%0d_iss_dest", k), {27'd0, iss_dest_o}, 32'(k));
            checkOutput($sformatf("drain%0d_iss_vj", k), iss_vj_o, 32'(100 + k));
            nextCycle();
        end
        idle(1'b1);
        @(negedge clk);
        checkOutput("drain_done_iss_valid", {31'd0, iss_valid_o}, 32'd0);
        nextCycle();

        // Flush with three held entries and a competing dispatch.
        for (int k = 1; k <= 3; k++) begin
            dispReady(5'(k), 32'(k), 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, ALU_ADD, 32'd1, 32'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("flush_iss_valid", {31'd0, iss_valid_o}, 32'd0);
        checkOutput("flush_iss_dest", {27'd0, iss_dest_o}, 32'd0);
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            @(negedge clk);
            checkOutput($sformatf("post_flush%0d_disp_ready", k), {31'd0, disp_ready_o}, 32'd1);
            checkOutput($sformatf("post_flush%0d_iss_valid", k), {31'd0, iss_valid_o}, 32'd0);
            nextCycle();
        end

        // Asynchronous reset in the middle of a cycle with pending and ready entries.
        applyStimulus(1'b1, ALU_ADD, 32'd0, 32'd1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, ALU_ADD, 32'd1, 32'd0, 5'd0, 1'b0, 5'd15, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        nextCycle();
        dispReady(5'd6, 32'd6, 1'b0);
        nextCycle();
        idle(1'b0);
        @(negedge clk);
        checkOutput("pre_reset_iss_valid", {31'd0, iss_valid_o}, 32'd1);
        checkOutput("pre_reset_iss_dest", {27'd0, iss_dest_o}, 32'd6);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_iss_valid", {31'd0, iss_valid_o}, 32'd0);
        checkOutput("async_reset_disp_ready", {31'd0, disp_ready_o}, 32'd1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd15, 32'h1234, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("post_reset%0d_iss_valid", k), {31'd0, iss_valid_o}, 32'd0);
            nextCycle();
            idle(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
